// File: rtl/fifo_uart_dumper_pkg.sv
// Shared framing constants, FSM encoding and byte-select helper for the FIFO-to-UART dumper.
package fifo_uart_dumper_pkg;

  localparam logic       START_BIT         = 1'b0;
  localparam logic       STOP_BIT          = 1'b1;
  localparam int         DATA_BITS         = 8;
  localparam int         BITS_PER_BYTE     = DATA_BITS + 2;
  localparam int         FRAME_BYTES       = 5;
  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_LATCH = 3'd3,
    ST_SEND  = 3'd4
  } state_t;

  // Byte idx of a 32-bit word, idx 0 being the least significant byte.
  function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
    return word[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser. o_done marks the last cycle of the stop bit so the next
// byte can be loaded in that same cycle and follow without an idle gap.
module uart_tx_byte
  import fifo_uart_dumper_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                 i_clk,
  input  logic                 mrst,
  input  logic                 i_load,
  input  logic [DATA_BITS-1:0] i_byte,
  output logic                 o_tx,
  output logic                 o_done
);

  localparam int             CW        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]  BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]     BIT_LAST  = 4'(BITS_PER_BYTE - 1);

  logic                active;
  logic [CW-1:0]       baud_cnt;
  logic [3:0]          bit_idx;
  // Data and stop bits still to go; the start bit goes straight to o_tx on load.
  logic [DATA_BITS:0]  shift;
  logic                bit_end;
  logic                last_bit;

  assign bit_end  = (baud_cnt == BAUD_LAST);
  assign last_bit = (bit_idx == BIT_LAST);
  assign o_done   = active && bit_end && last_bit;

  always_ff @(posedge i_clk or posedge mrst) begin
    if (mrst) begin
      active   <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      o_tx     <= STOP_BIT;
    end else if (i_load) begin
      active   <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= {STOP_BIT, i_byte};
      o_tx     <= START_BIT;
    end else if (active) begin
      if (bit_end) begin
        baud_cnt <= '0;
        if (last_bit) begin
          active  <= 1'b0;
          bit_idx <= '0;
          o_tx    <= STOP_BIT;
        end else begin
          bit_idx <= bit_idx + 4'd1;
          shift   <= {STOP_BIT, shift[DATA_BITS:1]};
          o_tx    <= shift[0];
        end
      end else begin
        baud_cnt <= baud_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/fifo_uart_dumper.sv
// Drains 32-bit words from the channel FIFO and sends each as a 5-byte UART frame:
// sync byte, then the word bytes least significant first.
module fifo_uart_dumper
  import fifo_uart_dumper_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 434,
  parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE
) (
  input  logic        i_clk,
  input  logic        mrst,
  input  logic        i_enable,
  input  logic        i_empty,
  input  logic [31:0] i_q,
  output logic        o_rdreq,
  output logic        o_tx,
  output logic        o_busy,
  output logic [15:0] o_word_count,
  output state_t      dbg_state
);

  localparam logic [2:0] WORD_BYTES = 3'(FRAME_BYTES - 1);

  state_t      state;
  logic [31:0] word;
  logic [2:0]  byte_idx;
  logic        load;
  logic [7:0]  load_byte;
  logic        tx_done;

  assign dbg_state = state;

  // Loads are issued combinationally so a byte starts on the edge that ends the previous stop bit.
  always_comb begin
    load      = 1'b0;
    load_byte = SYNC_BYTE;
    if (state == ST_LATCH) begin
      load = 1'b1;
    end else if (state == ST_SEND && tx_done && byte_idx < WORD_BYTES) begin
      load      = 1'b1;
      load_byte = word_byte(word, byte_idx[1:0]);
    end
  end

  always_ff @(posedge i_clk or posedge mrst) begin
    if (mrst) begin
      state        <= ST_IDLE;
      o_rdreq      <= 1'b0;
      o_busy       <= 1'b0;
      o_word_count <= '0;
      word         <= '0;
      byte_idx     <= '0;
    end else begin
      o_rdreq <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_enable && !i_empty) begin
            state   <= ST_FETCH;
            o_rdreq <= 1'b1;
            o_busy  <= 1'b1;
          end
        end
        ST_FETCH: state <= ST_WAIT;
        ST_WAIT:  state <= ST_LATCH;
        ST_LATCH: begin
          word     <= i_q;
          byte_idx <= '0;
          state    <= ST_SEND;
        end
        ST_SEND: begin
          if (tx_done) begin
            if (byte_idx < WORD_BYTES) begin
              byte_idx <= byte_idx + 3'd1;
            end else begin
              o_word_count <= o_word_count + 16'd1;
              o_busy       <= 1'b0;
              state        <= ST_IDLE;
            end
          end
        end
        default: begin
          state  <= ST_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .i_clk (i_clk),
    .mrst  (mrst),
    .i_load(load),
    .i_byte(load_byte),
    .o_tx  (o_tx),
    .o_done(tx_done)
  );

endmodule

// File: tb/tb_fifo_uart_dumper.sv
// Scoreboard bench: dut_a runs at 4 clocks/bit, dut_b at 7 clocks/bit, each fed by a FIFO model.
module tb_fifo_uart_dumper;
  import fifo_uart_dumper_pkg::*;

  logic        clk;
  logic        rst_a, rst_b, en_a, en_b;
  logic        empty_a = 1'b1, empty_b = 1'b1;
  logic [31:0] q_a = '0, q_b = '0;
  logic        rdreq_a, rdreq_b, tx_a, tx_b, busy_a, busy_b;
  logic [15:0] wc_a, wc_b;
  state_t      st_a, st_b;

  logic [31:0] fifo_a[$], fifo_b[$];
  logic [7:0]  exp_q_a[$], exp_q_b[$];

  int total = 0, bad = 0, cyc = 0;
  int rd_cnt[2] = '{0, 0};
  int bytes_rx[2] = '{0, 0};
  int exp_wc[2] = '{0, 0};
  bit mon_on[2] = '{1'b1, 1'b1};

  fifo_uart_dumper #(.CLKS_PER_BIT(4), .SYNC_BYTE(8'hA5)) dut_a (
    .i_clk(clk), .mrst(rst_a), .i_enable(en_a), .i_empty(empty_a), .i_q(q_a),
    .o_rdreq(rdreq_a), .o_tx(tx_a), .o_busy(busy_a), .o_word_count(wc_a), .dbg_state(st_a)
  );

  fifo_uart_dumper #(.CLKS_PER_BIT(7), .SYNC_BYTE(8'hA5)) dut_b (
    .i_clk(clk), .mrst(rst_b), .i_enable(en_b), .i_empty(empty_b), .i_q(q_b),
    .o_rdreq(rdreq_b), .o_tx(tx_b), .o_busy(busy_b), .o_word_count(wc_b), .dbg_state(st_b)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // FIFO models: data appears one cycle after the read request
  initial forever begin
    @(posedge clk);
    if (rdreq_a && fifo_a.size() > 0) q_a <= fifo_a.pop_front();
    if (rdreq_b && fifo_b.size() > 0) q_b <= fifo_b.pop_front();
  end

  initial forever begin
    @(negedge clk);
    empty_a = (fifo_a.size() == 0);
    empty_b = (fifo_b.size() == 0);
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic tx_of(input int w);
    return (w == 0) ? tx_a : tx_b;
  endfunction

  function automatic int wc_of(input int w);
    return (w == 0) ? int'(wc_a) : int'(wc_b);
  endfunction

  // driver: frame holds the expected bytes, first-sent byte in the top 8 bits
  task automatic push_word(input int w, input logic [31:0] word, input logic [39:0] frame,
                           input bit expect_frame);
    logic [7:0] b;
    if (w == 0) fifo_a.push_back(word);
    else fifo_b.push_back(word);
    if (expect_frame) begin
      for (int i = 4; i >= 0; i--) begin
        b = frame[8*i +: 8];
        if (w == 0) exp_q_a.push_back(b);
        else exp_q_b.push_back(b);
      end
    end
  endtask

  task automatic wait_wc(input int w, input int target, input int budget);
    int n;
    n = 0;
    while (wc_of(w) != target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check((w == 0) ? "wait_word_count_a" : "wait_word_count_b", wc_of(w), target);
  endtask

  // Samples every cycle of a byte; any change inside a bit window breaks the shape.
  task automatic rx_byte(input int w, input int cpb, output logic [7:0] data, output bit ok);
    logic [9:0] bits;
    logic       cur;
    bits = '0;
    ok = 1'b1;
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < cpb; c++) begin
        if (b != 0 || c != 0) @(negedge clk);
        cur = tx_of(w);
        if (c == 0) bits[b] = cur;
        else if (cur !== bits[b]) ok = 1'b0;
      end
    end
    data = bits[8:1];
    if (bits[0] !== 1'b0 || bits[9] !== 1'b1) ok = 1'b0;
  endtask

  // monitor / scoreboard
  task automatic monitor(input int w);
    int         cpb, pos, st, fstart, prev;
    bit         pend, ok;
    logic [7:0] data, e;
    string      sfx;
    cpb = (w == 0) ? 4 : 7;
    sfx = (w == 0) ? "a" : "b";
    pos = 0; fstart = 0; prev = 0; pend = 1'b0;
    forever begin
      @(negedge clk);
      if (pend) begin
        check({"word_count_at_frame_end_", sfx}, wc_of(w), exp_wc[w]);
        pend = 1'b0;
      end
      if (mon_on[w] && tx_of(w) === 1'b0) begin
        st = cyc;
        if (pos == 0) fstart = st;
        else check({"byte_gap_", sfx}, st - prev, 10 * cpb);
        prev = st;
        rx_byte(w, cpb, data, ok);
        if (mon_on[w]) begin
          check({"bit_shape_", sfx}, int'(ok), 1);
          if ((w == 0 ? exp_q_a.size() : exp_q_b.size()) == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_byte_%s: got %0h expected none", sfx, data);
          end else begin
            e = (w == 0) ? exp_q_a.pop_front() : exp_q_b.pop_front();
            check({"rx_byte_", sfx}, int'(data), int'(e));
          end
          bytes_rx[w]++;
          if (pos == 4) begin
            check({"frame_len_", sfx}, st + 10 * cpb - fstart, 50 * cpb);
            exp_wc[w]++;
            pend = 1'b1;
          end
          pos = (pos + 1) % 5;
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  // read-request monitor: single-cycle pulses, never against an empty FIFO
  initial begin
    logic prev_a, prev_b;
    prev_a = 1'b0;
    prev_b = 1'b0;
    forever begin
      @(negedge clk);
      if (rdreq_a === 1'b1) begin
        if (!prev_a) rd_cnt[0]++;
        check("rdreq_has_data_a", int'(fifo_a.size() != 0), 1);
        check("rdreq_single_a", int'(prev_a), 0);
      end
      if (rdreq_b === 1'b1) begin
        if (!prev_b) rd_cnt[1]++;
        check("rdreq_has_data_b", int'(fifo_b.size() != 0), 1);
        check("rdreq_single_b", int'(prev_b), 0);
      end
      prev_a = rdreq_a;
      prev_b = rdreq_b;
    end
  end

  // stimulus
  initial begin
    int  n, base;
    bit  tx_low;
    rst_a = 1'b0; rst_b = 1'b0; en_a = 1'b0; en_b = 1'b0;
    #1 rst_a = 1'b1; rst_b = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_tx_a", int'(tx_a), 1);
    check("reset_rdreq_a", int'(rdreq_a), 0);
    check("reset_busy_a", int'(busy_a), 0);
    check("reset_word_count_a", int'(wc_a), 0);
    check("reset_state_a", int'(st_a), int'(ST_IDLE));
    check("reset_tx_b", int'(tx_b), 1);
    rst_a = 1'b0; rst_b = 1'b0;
    repeat (2) @(negedge clk);

    // single word
    push_word(0, 32'h12345678, 40'hA5_78_56_34_12, 1'b1);
    en_a = 1'b1;
    repeat (20) @(negedge clk);
    check("busy_during_frame_a", int'(busy_a), 1);
    wait_wc(0, 1, 400);
    repeat (2) @(negedge clk);
    check("busy_after_single_a", int'(busy_a), 0);
    check("rdreq_pulses_single_a", rd_cnt[0], 1);

    // empty FIFO with enable held
    tx_low = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (tx_a !== 1'b1) tx_low = 1'b1;
    end
    check("tx_idle_when_empty_a", int'(tx_low), 0);
    check("rdreq_pulses_empty_a", rd_cnt[0], 1);
    check("busy_when_empty_a", int'(busy_a), 0);

    // back-to-back words
    push_word(0, 32'h00000000, 40'hA5_00_00_00_00, 1'b1);
    push_word(0, 32'hFFFFFFFF, 40'hA5_FF_FF_FF_FF, 1'b1);
    push_word(0, 32'hDEADBEEF, 40'hA5_EF_BE_AD_DE, 1'b1);
    wait_wc(0, 4, 1000);
    repeat (5) @(negedge clk);
    check("rdreq_pulses_b2b_a", rd_cnt[0], 4);
    check("bytes_b2b_a", bytes_rx[0], 20);
    check("exp_drained_b2b_a", exp_q_a.size(), 0);

    // enable dropped during byte 2 with two words queued
    base = bytes_rx[0];
    push_word(0, 32'hCAFEF00D, 40'hA5_0D_F0_FE_CA, 1'b1);
    push_word(0, 32'h0BADC0DE, 40'h0, 1'b0);
    n = 0;
    while (bytes_rx[0] < base + 2 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("reached_byte2_a", bytes_rx[0] - base, 2);
    en_a = 1'b0;
    wait_wc(0, 5, 300);
    repeat (300) @(negedge clk);
    check("word_count_after_drop_a", int'(wc_a), 5);
    check("rdreq_pulses_drop_a", rd_cnt[0], 5);
    check("fifo_left_after_drop_a", fifo_a.size(), 1);
    check("exp_drained_drop_a", exp_q_a.size(), 0);
    check("busy_after_drop_a", int'(busy_a), 0);

    // bit timing at 7 clocks per bit
    push_word(1, 32'h5A3C0F96, 40'hA5_96_0F_3C_5A, 1'b1);
    en_b = 1'b1;
    wait_wc(1, 1, 600);
    en_b = 1'b0;
    repeat (5) @(negedge clk);
    check("rdreq_pulses_b", rd_cnt[1], 1);
    check("bytes_b", bytes_rx[1], 5);
    check("exp_drained_b", exp_q_b.size(), 0);

    // reset in the middle of a byte, while D1 (low) of the sync byte is on the line
    mon_on[1] = 1'b0;
    push_word(1, 32'h00000001, 40'h0, 1'b0);
    en_b = 1'b1;
    n = 0;
    while (tx_b !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("start_bit_seen_b", int'(tx_b), 0);
    repeat (15) @(negedge clk);
    check("tx_low_before_reset_b", int'(tx_b), 0);
    #2 rst_b = 1'b1;
    #1;
    check("mid_byte_reset_tx_b", int'(tx_b), 1);
    check("mid_byte_reset_busy_b", int'(busy_b), 0);
    check("mid_byte_reset_word_count_b", int'(wc_b), 0);
    check("mid_byte_reset_state_b", int'(st_b), int'(ST_IDLE));
    en_b = 1'b0;
    @(negedge clk);
    rst_b = 1'b0;
    repeat (20) @(negedge clk);
    check("tx_idle_after_reset_b", int'(tx_b), 1);
    check("busy_idle_after_reset_b", int'(busy_b), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
